gray_cnt_sequencer: RTL and testbench

Command-driven controller for the Gray-code counter datapath. It accepts step, load, clear and (optionally) free-run commands over a valid/ready handshake. It sequences a binary count register by INCREMENT per step and presents the count in both Gray and binary form. It signals completion and wrap-around with one-cycle pulses, so a single Gray counter can be stepped under software or FSM control instead of free-running.

---
 rtl/gray_cnt_sequencer_if.sv | 12 +
 rtl/gray_cnt_sequencer.sv | 143 ++++++++++++++
 tb/tb_gray_cnt_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gray_cnt_sequencer_if.sv
// Command channel for gray_cnt_sequencer: valid/ready handshake carrying opcode and argument.
interface gray_cnt_sequencer_if #(
  parameter int BIT_SIZE = 4
);
  logic                valid;
  logic                ready;
  logic [1:0]          op;
  logic [BIT_SIZE-1:0] arg;

  modport master (output valid, output op, output arg, input ready);
  modport slave  (input valid, input op, input arg, output ready);
endinterface

// File: rtl/gray_cnt_sequencer.sv
// Command-driven Gray/binary counter sequencer (STEP, LOAD, CLEAR, FREE_RUN).
// Optional feature: define GRAY_CNT_SEQ_FREE_RUN_EN to build the free-running mode for opcode 11.
module gray_cnt_sequencer #(
  parameter int BIT_SIZE  = 4,
  parameter int INCREMENT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  gray_cnt_sequencer_if.slave  cmd,
  input  logic                 stop_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 wrap_o,
  output logic [BIT_SIZE-1:0]  cnt_bin_o,
  output logic [BIT_SIZE-1:0]  cnt_gray_o
);

  localparam logic [1:0] OP_STEP  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_FREE  = 2'b11;

  localparam logic [BIT_SIZE-1:0] INC_V = BIT_SIZE'(INCREMENT);
  localparam logic [BIT_SIZE-1:0] ONE_V = BIT_SIZE'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [BIT_SIZE-1:0] remaining_q;
  logic [BIT_SIZE-1:0] rem_nxt;
  logic [BIT_SIZE-1:0] cnt_nxt;
  logic                wrap_nxt;
  logic [BIT_SIZE:0]   sum;
  logic                accept;
  logic                advance;
  logic                last_step;

  function automatic logic [BIT_SIZE:0] add_inc(input logic [BIT_SIZE-1:0] a);
    return {1'b0, a} + {1'b0, INC_V};
  endfunction

  function automatic logic [BIT_SIZE-1:0] to_gray(input logic [BIT_SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign accept  = cmd.valid && (state_q == S_IDLE);
  assign advance = (state_q == S_RUN) && !stop_i;
  assign sum     = add_inc(cnt_bin_o);

`ifdef GRAY_CNT_SEQ_FREE_RUN_EN
  logic free_q;
  logic free_nxt;

  // A free-running command ignores the step count and only leaves RUN on stop.
  assign last_step = !free_q && (remaining_q == ONE_V);

  always_comb begin
    free_nxt = free_q;
    if (accept) free_nxt = (cmd.op == OP_FREE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) free_q <= 1'b0;
    else         free_q <= free_nxt;
  end
`else
  assign last_step = (remaining_q == ONE_V);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.valid) begin
          case (cmd.op)
            OP_STEP:  state_nxt = (cmd.arg == '0) ? S_DONE : S_RUN;
`ifdef GRAY_CNT_SEQ_FREE_RUN_EN
            OP_FREE:  state_nxt = S_RUN;
`else
            OP_FREE:  state_nxt = S_DONE;
`endif
            default:  state_nxt = S_DONE;
          endcase
        end
      end
      S_RUN: begin
        if (stop_i || last_step) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd.ready = (state_q == S_IDLE);
    busy_o    = (state_q == S_RUN);
    done_o    = (state_q == S_DONE);
  end

  // Count, step budget and wrap flag all load on the accept edge or advance in RUN.
  always_comb begin
    cnt_nxt  = cnt_bin_o;
    rem_nxt  = remaining_q;
    wrap_nxt = 1'b0;
    if (accept) begin
      case (cmd.op)
        OP_STEP:  rem_nxt = cmd.arg;
        OP_LOAD:  cnt_nxt = cmd.arg;
        OP_CLEAR: cnt_nxt = '0;
        default:  ;
      endcase
    end else if (advance) begin
      cnt_nxt  = sum[BIT_SIZE-1:0];
      wrap_nxt = sum[BIT_SIZE];
      rem_nxt  = remaining_q - ONE_V;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      remaining_q <= '0;
      cnt_bin_o   <= '0;
      cnt_gray_o  <= '0;
      wrap_o      <= 1'b0;
    end else begin
      remaining_q <= rem_nxt;
      cnt_bin_o   <= cnt_nxt;
      cnt_gray_o  <= to_gray(cnt_nxt);
      wrap_o      <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_gray_cnt_sequencer.sv
// Directed bench for gray_cnt_sequencer (BIT_SIZE=4, INCREMENT=1) with hand-computed expectations.
module tb_gray_cnt_sequencer;

  localparam logic [1:0] OP_STEP  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_FREE  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop;
  logic       busy, done, wrap;
  logic [3:0] cnt_bin, cnt_gray;
  int         total = 0;
  int         bad   = 0;

  gray_cnt_sequencer_if #(.BIT_SIZE(4)) cmd_if ();

  gray_cnt_sequencer #(.BIT_SIZE(4), .INCREMENT(1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd        (cmd_if),
    .stop_i     (stop),
    .busy_o     (busy),
    .done_o     (done),
    .wrap_o     (wrap),
    .cnt_bin_o  (cnt_bin),
    .cnt_gray_o (cnt_gray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge; returns in the cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] arg);
    cmd_if.valid = 1'b1;
    cmd_if.op    = op;
    cmd_if.arg   = arg;
    tick();
    cmd_if.valid = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] b, input logic [3:0] g);
    check({tag, "_bin"}, 32'(cnt_bin), 32'(b));
    check({tag, "_gray"}, 32'(cnt_gray), 32'(g));
  endtask

  initial begin
    rst_n        = 1'b0;
    stop         = 1'b0;
    cmd_if.valid = 1'b0;
    cmd_if.op    = OP_STEP;
    cmd_if.arg   = 4'd0;
    tick();
    tick();
    chk_cnt("rst", 4'd0, 4'd0);
    check("rst_ready", 32'(cmd_if.ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wrap", 32'(wrap), 0);
    rst_n = 1'b1;
    tick();

    // STEP 3 from 0: Gray 0,1,3,2
    issue(OP_STEP, 4'd3);
    check("s3_busy0", 32'(busy), 1);
    chk_cnt("s3_c0", 4'd0, 4'd0);
    tick();
    check("s3_busy1", 32'(busy), 1);
    chk_cnt("s3_c1", 4'd1, 4'd1);
    tick();
    check("s3_busy2", 32'(busy), 1);
    chk_cnt("s3_c2", 4'd2, 4'd3);
    tick();
    check("s3_done", 32'(done), 1);
    check("s3_busy3", 32'(busy), 0);
    chk_cnt("s3_c3", 4'd3, 4'd2);
    tick();
    check("s3_done_off", 32'(done), 0);
    check("s3_ready", 32'(cmd_if.ready), 1);

    // LOAD 14 then STEP 3: 14,15,0,1 with wrap after 15->0
    issue(OP_LOAD, 4'd14);
    check("ld_done", 32'(done), 1);
    chk_cnt("ld", 4'd14, 4'd9);
    tick();
    issue(OP_STEP, 4'd3);
    chk_cnt("w_c0", 4'd14, 4'd9);
    tick();
    chk_cnt("w_c1", 4'd15, 4'd8);
    check("w_wrap1", 32'(wrap), 0);
    tick();
    chk_cnt("w_c2", 4'd0, 4'd0);
    check("w_wrap2", 32'(wrap), 1);
    tick();
    chk_cnt("w_c3", 4'd1, 4'd1);
    check("w_wrap3", 32'(wrap), 0);
    check("w_done", 32'(done), 1);
    tick();

    // STEP 10 aborted on the 4th RUN edge; a LOAD held during RUN must be ignored
    issue(OP_CLEAR, 4'd0);
    chk_cnt("clr", 4'd0, 4'd0);
    tick();
    cmd_if.valid = 1'b1;
    cmd_if.op    = OP_STEP;
    cmd_if.arg   = 4'd10;
    tick();
    cmd_if.op    = OP_LOAD;
    cmd_if.arg   = 4'd7;
    check("st_ready_run", 32'(cmd_if.ready), 0);
    tick();
    tick();
    tick();
    chk_cnt("st_c3", 4'd3, 4'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    cmd_if.valid = 1'b0;
    check("st_done", 32'(done), 1);
    check("st_busy", 32'(busy), 0);
    chk_cnt("st_stop", 4'd3, 4'd2);
    tick();
    check("st_ready", 32'(cmd_if.ready), 1);
    chk_cnt("st_after", 4'd3, 4'd2);

    // STEP 0 and CLEAR back-to-back with valid held high
    cmd_if.valid = 1'b1;
    cmd_if.op    = OP_STEP;
    cmd_if.arg   = 4'd0;
    tick();
    cmd_if.op    = OP_CLEAR;
    check("b2b_done0", 32'(done), 1);
    check("b2b_busy0", 32'(busy), 0);
    chk_cnt("b2b_c0", 4'd3, 4'd2);
    tick();
    check("b2b_gap_done", 32'(done), 0);
    check("b2b_gap_ready", 32'(cmd_if.ready), 1);
    chk_cnt("b2b_gap", 4'd3, 4'd2);
    tick();
    cmd_if.valid = 1'b0;
    check("b2b_done1", 32'(done), 1);
    chk_cnt("b2b_c1", 4'd0, 4'd0);
    tick();
    check("b2b_idle", 32'(cmd_if.ready), 1);

    // Reset in the middle of STEP 8
    issue(OP_LOAD, 4'd5);
    tick();
    issue(OP_STEP, 4'd8);
    tick();
    tick();
    chk_cnt("rr_pre", 4'd7, 4'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_cnt("rr", 4'd0, 4'd0);
    check("rr_busy", 32'(busy), 0);
    check("rr_ready", 32'(cmd_if.ready), 1);
    check("rr_done", 32'(done), 0);
    check("rr_wrap", 32'(wrap), 0);
    tick();
    check("rr_done2", 32'(done), 0);
    chk_cnt("rr2", 4'd0, 4'd0);

    // Opcode 11
    issue(OP_LOAD, 4'd6);
    tick();
    issue(OP_FREE, 4'd0);
`ifdef GRAY_CNT_SEQ_FREE_RUN_EN
    check("fr_busy", 32'(busy), 1);
    for (int i = 0; i < 12; i++) tick();
    check("fr_busy12", 32'(busy), 1);
    chk_cnt("fr_c12", 4'd2, 4'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("fr_done", 32'(done), 1);
    chk_cnt("fr_stop", 4'd2, 4'd3);
    tick();
    check("fr_ready", 32'(cmd_if.ready), 1);
`else
    check("op11_done", 32'(done), 1);
    check("op11_busy", 32'(busy), 0);
    chk_cnt("op11", 4'd6, 4'd5);
    tick();
    check("op11_done_off", 32'(done), 0);
    check("op11_ready", 32'(cmd_if.ready), 1);
    chk_cnt("op11_after", 4'd6, 4'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
